// File: rtl/minimig_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minimig_mem_pkg : shared types, constants and helpers for the mapper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package minimig_mem_pkg;

  // Wide enough for CHIP_BLOCKS up to 8 and SLOW_BLOCKS up to 7
  localparam int CFG_CODE_W     = 3;
  localparam int BANK_W_DEFAULT = 8;

  typedef struct packed {
    logic [CFG_CODE_W-1:0] chip;
    logic [CFG_CODE_W-1:0] slow;
    logic                  aron;
    logic                  ecs;
  } cfg_t;

  localparam cfg_t C_RESET_CFG = '0;

  // Smallest 2^k-1 that is >= code
  function automatic int next_pow2_mask(input int code);
    int m;
    m = 0;
    for (int k = 0; k < 8; k++) begin
      if (m < code) m = (m << 1) | 1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/minimig_bankmap_comb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minimig_bankmap_comb : block selects -> one-hot bank map (pure comb)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module minimig_bankmap_comb
  import minimig_mem_pkg::*;
#(
  parameter int CHIP_BLOCKS = 4,
  parameter int SLOW_BLOCKS = 3,
  parameter int SLOW_BANKS  = 2,
  localparam int BANK_W     = CHIP_BLOCKS + SLOW_BANKS + 2
) (
  input  logic [CHIP_BLOCKS-1:0] chip_sel,
  input  logic [SLOW_BLOCKS-1:0] slow_sel,
  input  logic                   kick,
  input  logic                   kick1mb,
  input  logic                   cart,
  input  cfg_t                   cfg,
  output logic [BANK_W-1:0]      map
);

  localparam int C_SLOW_N   = (SLOW_BLOCKS < SLOW_BANKS) ? SLOW_BLOCKS : SLOW_BANKS;
  localparam int C_CART_BIT = CHIP_BLOCKS + SLOW_BANKS - 1;

  int   w_chip;
  int   w_slow;
  int   w_mask;
  int   w_lim;
  logic w_hole;
  logic w_unused_slow;

  // Slow selects past the reserved banks can never map anywhere
  assign w_unused_slow = ^slow_sel;

  always_comb begin
    w_chip = int'(cfg.chip);
    w_slow = int'(cfg.slow);
    w_mask = next_pow2_mask(w_chip);
    w_hole = cfg.ecs && (w_chip == 0) && (w_slow != 0);
    w_lim  = (w_slow < SLOW_BANKS) ? w_slow : SLOW_BANKS;
    if (cfg.aron && (w_lim > 0)) w_lim = w_lim - 1;

    map = '0;
    for (int b = 0; b < CHIP_BLOCKS; b++) begin
      for (int i = 0; i < CHIP_BLOCKS; i++) begin
        if (((i & w_mask) == b) && (b <= w_chip) && !(w_hole && ((i % 2) == 1)))
          map[b] = map[b] | chip_sel[i];
      end
    end
    for (int j = 0; j < C_SLOW_N; j++) begin
      if (j < w_lim) map[CHIP_BLOCKS+j] = slow_sel[j];
    end
    // Cart borrows the top slow bank, which the reduced limit leaves free
    if (cfg.aron) map[C_CART_BIT] = map[C_CART_BIT] | cart;
    map[BANK_W-1] = kick;
    map[BANK_W-2] = kick1mb;
  end

endmodule
`default_nettype wire

// File: rtl/minimig_bankmapper_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minimig_bankmapper_gen : staged-config registered bank mapper         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module minimig_bankmapper_gen
  import minimig_mem_pkg::*;
#(
  parameter int CHIP_BLOCKS = 4,
  parameter int SLOW_BLOCKS = 3,
  parameter int SLOW_BANKS  = 2,
  parameter int ERRCNT_W    = 8,
  localparam int CW         = $clog2(CHIP_BLOCKS),
  localparam int SW         = $clog2(SLOW_BLOCKS + 1),
  localparam int BANK_W     = CHIP_BLOCKS + SLOW_BANKS + 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHIP_BLOCKS-1:0] chip_sel,
  input  logic [SLOW_BLOCKS-1:0] slow_sel,
  input  logic                   kick,
  input  logic                   kick1mb,
  input  logic                   cart,
  input  logic                   sel_valid,
  input  logic                   bus_idle,
  input  logic                   cfg_wr,
  input  logic [CW-1:0]          cfg_chip,
  input  logic [SW-1:0]          cfg_slow,
  input  logic                   cfg_aron,
  input  logic                   cfg_ecs,
  output logic [BANK_W-1:0]      bank,
  output logic                   bank_valid,
  output logic                   cfg_pending,
  output logic                   unmapped,
  output logic [ERRCNT_W-1:0]    unmapped_cnt
);

  cfg_t                r_stage;
  cfg_t                r_active;
  logic                r_pending;
  logic [BANK_W-1:0]   r_bank;
  logic                r_bank_valid;
  logic                r_unmapped;
  logic [ERRCNT_W-1:0] r_cnt;

  cfg_t                w_cfg_in;
  logic [BANK_W-1:0]   w_map;
  logic                w_any_sel;
  logic                w_unmapped;

  always_comb begin
    w_cfg_in      = C_RESET_CFG;
    w_cfg_in.chip = CFG_CODE_W'(cfg_chip);
    w_cfg_in.slow = CFG_CODE_W'(cfg_slow);
    w_cfg_in.aron = cfg_aron;
    w_cfg_in.ecs  = cfg_ecs;
  end

  minimig_bankmap_comb #(
    .CHIP_BLOCKS (CHIP_BLOCKS),
    .SLOW_BLOCKS (SLOW_BLOCKS),
    .SLOW_BANKS  (SLOW_BANKS)
  ) u_map (
    .chip_sel (chip_sel),
    .slow_sel (slow_sel),
    .kick     (kick),
    .kick1mb  (kick1mb),
    .cart     (cart),
    .cfg      (r_active),
    .map      (w_map)
  );

  assign w_any_sel  = (|chip_sel) | (|slow_sel) | kick | kick1mb | cart;
  assign w_unmapped = sel_valid && (w_map == '0) && w_any_sel;

  // A fresh write always restages, so apply only happens on quiet cfg cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage   <= C_RESET_CFG;
      r_active  <= C_RESET_CFG;
      r_pending <= 1'b0;
    end else if (cfg_wr) begin
      r_stage   <= w_cfg_in;
      r_pending <= 1'b1;
    end else if (r_pending && bus_idle) begin
      r_active  <= r_stage;
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank       <= '0;
      r_bank_valid <= 1'b0;
      r_unmapped   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_bank       <= sel_valid ? w_map : '0;
      r_bank_valid <= sel_valid;
      r_unmapped   <= w_unmapped;
      if (w_unmapped && (r_cnt != '1)) r_cnt <= r_cnt + ERRCNT_W'(1);
    end
  end

  assign bank         = r_bank;
  assign bank_valid   = r_bank_valid;
  assign cfg_pending  = r_pending;
  assign unmapped     = r_unmapped;
  assign unmapped_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_minimig_bankmapper_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_minimig_bankmapper_gen : directed + random checks against a model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_minimig_bankmapper_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] chip_sel;
  logic [2:0] slow_sel;
  logic       kick, kick1mb, cart, sel_valid, bus_idle, cfg_wr;
  logic [1:0] cfg_chip;
  logic [1:0] cfg_slow;
  logic       cfg_aron, cfg_ecs;
  logic [7:0] bank;
  logic       bank_valid, cfg_pending, unmapped;
  logic [7:0] unmapped_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: active config, staged config, pending flag, error count
  int a_chip, a_slow, a_aron, a_ecs;
  int s_chip, s_slow, s_aron, s_ecs;
  int m_pending, m_cnt;

  minimig_bankmapper_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .chip_sel     (chip_sel),
    .slow_sel     (slow_sel),
    .kick         (kick),
    .kick1mb      (kick1mb),
    .cart         (cart),
    .sel_valid    (sel_valid),
    .bus_idle     (bus_idle),
    .cfg_wr       (cfg_wr),
    .cfg_chip     (cfg_chip),
    .cfg_slow     (cfg_slow),
    .cfg_aron     (cfg_aron),
    .cfg_ecs      (cfg_ecs),
    .bank         (bank),
    .bank_valid   (bank_valid),
    .cfg_pending  (cfg_pending),
    .unmapped     (unmapped),
    .unmapped_cnt (unmapped_cnt)
  );

  always #5 clk = ~clk;

  function automatic int ref_map(int chip, int slow, int aron, int ecs,
                                 int cs, int ss, int kk, int k1, int ct);
    int res, m, lim;
    res = 0;
    m   = (1 << $clog2(chip + 1)) - 1;
    for (int i = 0; i < 4; i++) begin
      if (((cs >> i) & 1) == 1) begin
        if (!(ecs == 1 && chip == 0 && slow != 0 && (i % 2) == 1)) begin
          if ((i & m) <= chip) res = res | (1 << (i & m));
        end
      end
    end
    lim = (slow < 2) ? slow : 2;
    if (aron == 1 && lim > 0) lim = lim - 1;
    for (int j = 0; j < 3; j++) begin
      if (((ss >> j) & 1) == 1 && j < lim) res = res | (1 << (4 + j));
    end
    if (aron == 1 && ct == 1) res = res | 8'h20;
    if (kk == 1) res = res | 8'h80;
    if (k1 == 1) res = res | 8'h40;
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_chip = 0; a_slow = 0; a_aron = 0; a_ecs = 0;
    s_chip = 0; s_slow = 0; s_aron = 0; s_ecs = 0;
    m_pending = 0; m_cnt = 0;
  endtask

  // One clock: predict from pre-edge state, advance model, compare at edge+1
  task automatic cycle();
    int map, exp_bank, exp_unm, any;
    map = ref_map(a_chip, a_slow, a_aron, a_ecs, int'(chip_sel), int'(slow_sel),
                  int'(kick), int'(kick1mb), int'(cart));
    exp_bank = sel_valid ? map : 0;
    any      = (chip_sel != 0 || slow_sel != 0 || kick || kick1mb || cart) ? 1 : 0;
    exp_unm  = (sel_valid && map == 0 && any == 1) ? 1 : 0;
    if (exp_unm == 1 && m_cnt < 255) m_cnt++;
    if (cfg_wr) begin
      s_chip = int'(cfg_chip); s_slow = int'(cfg_slow);
      s_aron = int'(cfg_aron); s_ecs = int'(cfg_ecs);
      m_pending = 1;
    end else if (m_pending == 1 && bus_idle) begin
      a_chip = s_chip; a_slow = s_slow; a_aron = s_aron; a_ecs = s_ecs;
      m_pending = 0;
    end
    @(posedge clk);
    #1;
    check("bank", 32'(bank), 32'(exp_bank));
    check("bank_valid", 32'(bank_valid), 32'(sel_valid));
    check("unmapped", 32'(unmapped), 32'(exp_unm));
    check("unmapped_cnt", 32'(unmapped_cnt), 32'(m_cnt));
    check("cfg_pending", 32'(cfg_pending), 32'(m_pending));
  endtask

  task automatic clear_sel();
    chip_sel = '0; slow_sel = '0; kick = 0; kick1mb = 0; cart = 0; sel_valid = 0;
  endtask

  task automatic set_cfg(input int c, input int s, input int a, input int e);
    clear_sel();
    cfg_chip = 2'(c); cfg_slow = 2'(s); cfg_aron = 1'(a); cfg_ecs = 1'(e);
    cfg_wr = 1; bus_idle = 1;
    cycle();
    cfg_wr = 0;
    cycle();
  endtask

  task automatic sel(input logic [3:0] cs, input logic [2:0] ss,
                     input logic kk, input logic k1, input logic ct);
    chip_sel = cs; slow_sel = ss; kick = kk; kick1mb = k1; cart = ct; sel_valid = 1;
    cycle();
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    check("rst_bank", 32'(bank), 32'h0);
    check("rst_bank_valid", 32'(bank_valid), 32'h0);
    check("rst_pending", 32'(cfg_pending), 32'h0);
    check("rst_unmapped", 32'(unmapped), 32'h0);
    check("rst_cnt", 32'(unmapped_cnt), 32'h0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    clear_sel();
    bus_idle = 1; cfg_wr = 0;
    cfg_chip = 0; cfg_slow = 0; cfg_aron = 0; cfg_ecs = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Chip aliasing with a 2-block config
    set_cfg(1, 0, 0, 0);
    sel(4'b0100, 3'b000, 0, 0, 0);
    check("tp_chip1_b2", 32'(bank), 32'h01);
    check("tp_chip1_valid", 32'(bank_valid), 32'h1);
    sel(4'b1000, 3'b000, 0, 0, 0);
    check("tp_chip1_b3", 32'(bank), 32'h02);

    // Block above the configured size drops out
    set_cfg(2, 0, 0, 0);
    sel(4'b1000, 3'b000, 0, 0, 0);
    check("tp_chip2_drop", 32'(bank), 32'h00);
    check("tp_chip2_unm", 32'(unmapped), 32'h1);
    check("tp_chip2_cnt", 32'(unmapped_cnt), 32'h1);
    sel(4'b0100, 3'b000, 0, 0, 0);
    check("tp_chip2_b2", 32'(bank), 32'h04);

    // ECS hole and slow limit
    set_cfg(0, 1, 0, 1);
    sel(4'b0010, 3'b000, 0, 0, 0);
    check("tp_ecs_hole", 32'(unmapped), 32'h1);
    sel(4'b0000, 3'b001, 0, 0, 0);
    check("tp_slow0", 32'(bank), 32'h10);
    sel(4'b0000, 3'b010, 0, 0, 0);
    check("tp_slow1_drop", 32'(unmapped), 32'h1);

    // Action Replay takes the top slow bank
    set_cfg(0, 2, 1, 0);
    sel(4'b0000, 3'b000, 0, 0, 1);
    check("tp_cart", 32'(bank), 32'h20);
    sel(4'b0000, 3'b010, 0, 0, 0);
    check("tp_aron_slow", 32'(unmapped), 32'h1);
    sel(4'b0000, 3'b000, 1, 0, 0);
    check("tp_kick", 32'(bank), 32'h80);
    sel(4'b0000, 3'b000, 0, 1, 0);
    check("tp_kick1mb", 32'(bank), 32'h40);

    // Staged config held off while the bus is busy
    clear_sel();
    cfg_chip = 1; cfg_slow = 0; cfg_aron = 0; cfg_ecs = 0;
    cfg_wr = 1; bus_idle = 0;
    cycle();
    cfg_wr = 0;
    for (int n = 0; n < 5; n++) begin
      sel(4'b1000, 3'b000, 0, 0, 0);
      check("hold_pending", 32'(cfg_pending), 32'h1);
      check("hold_oldmap", 32'(bank), 32'h01);
    end
    bus_idle = 1;
    sel(4'b1000, 3'b000, 0, 0, 0);
    check("apply_pending", 32'(cfg_pending), 32'h0);
    check("apply_edge_old", 32'(bank), 32'h01);
    sel(4'b1000, 3'b000, 0, 0, 0);
    check("apply_newmap", 32'(bank), 32'h02);

    // Reset while pending discards the staged config
    clear_sel();
    cfg_chip = 3; cfg_slow = 2; cfg_aron = 1; cfg_ecs = 0;
    cfg_wr = 1; bus_idle = 0;
    cycle();
    cfg_wr = 0;
    check("pre_rst_pending", 32'(cfg_pending), 32'h1);
    do_reset();
    bus_idle = 1;
    clear_sel();
    repeat (2) cycle();
    sel(4'b1000, 3'b000, 0, 0, 0);
    check("rst_cfg_chip", 32'(bank), 32'h01);
    sel(4'b0000, 3'b000, 0, 0, 1);
    check("rst_cfg_cart", 32'(unmapped), 32'h1);
    check("rst_cfg_cnt", 32'(unmapped_cnt), 32'h1);

    // Randomised traffic with occasional config writes
    for (int n = 0; n < 400; n++) begin
      chip_sel  = 4'($urandom & $urandom);
      slow_sel  = 3'($urandom & $urandom);
      kick      = ($urandom % 8) == 0;
      kick1mb   = ($urandom % 8) == 0;
      cart      = ($urandom % 4) == 0;
      sel_valid = ($urandom % 4) != 0;
      bus_idle  = ($urandom % 2) == 0;
      cfg_wr    = ($urandom % 8) == 0;
      cfg_chip  = 2'($urandom);
      cfg_slow  = 2'($urandom);
      cfg_aron  = 1'($urandom);
      cfg_ecs   = 1'($urandom);
      cycle();
    end
    cfg_wr = 0;

    // Counter saturation
    set_cfg(2, 0, 0, 0);
    for (int n = 0; n < 300; n++) sel(4'b1000, 3'b000, 0, 0, 0);
    check("sat_cnt", 32'(unmapped_cnt), 32'hFF);
    check("sat_unm", 32'(unmapped), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minimig_bankmapper_gen.md
Name: minimig_bankmapper_gen

Overview:
Parametrised, registered successor of the chip/slow/kick bank mapper. It maps physical 512 KB block selects onto a one-hot bank-select vector for the SDRAM/SRAM controller. Chip and slow block counts are generic, and chip aliasing is computed rather than tabled. A staged memory configuration takes effect only while the bus is idle, and unmapped accesses are flagged and counted. It sits between the address decoder (gary) and the memory controller.

Parameters:
CHIP_BLOCKS, 4, number of 512 KB chip blocks (power of two, 2..8)
SLOW_BLOCKS, 3, number of 512 KB slow-RAM select inputs (1..7)
SLOW_BANKS, 2, physical bank bits reserved for slow RAM (1..4)
ERRCNT_W, 8, width of the unmapped-access counter
Derived: CW = clog2(CHIP_BLOCKS); SW = clog2(SLOW_BLOCKS+1); BANK_W = CHIP_BLOCKS+SLOW_BANKS+2 (default 8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
chip_sel  in  CHIP_BLOCKS  chip block selects from decoder
slow_sel  in  SLOW_BLOCKS  slow block selects
kick  in  1  Kickstart range select
kick1mb  in  1  1 MB Kickstart upper half
cart  in  1  Action Replay range select
sel_valid  in  1  qualifies selects this cycle
bus_idle  in  1  no memory cycle in flight
cfg_wr  in  1  load staged configuration
cfg_chip  in  CW  chip size code (n+1 blocks)
cfg_slow  in  SW  slow size code (number of slow blocks)
cfg_aron  in  1  Action Replay enable
cfg_ecs  in  1  ECS enable
bank  out  BANK_W  registered bank select
bank_valid  out  1  bank qualifier
cfg_pending  out  1  staged config not yet applied
unmapped  out  1  one-cycle pulse: valid select hit no bank
unmapped_cnt  out  ERRCNT_W  saturating count of unmapped accesses

Behaviour:
- Reset (async, reset_n=0): bank=0, bank_valid=0, cfg_pending=0, unmapped=0, unmapped_cnt=0. Active config = chip 0, slow 0, aron 0, ecs 0. Staged config is also cleared.
- Config staging:
  - cfg_wr=1 captures all cfg_* into the staged register and sets cfg_pending.
  - On any cycle with cfg_pending=1, bus_idle=1 and cfg_wr=0, the staged config is copied to the active config and cfg_pending clears.
  - cfg_wr wins over apply in the same cycle: the new value is staged and is applied on a later idle cycle.
  - Reset mid-pending discards the staged config.
- Chip mapping (combinational on the active config):
  - m = smallest 2^k-1 with m >= cfg_chip.
  - chip_sel[i] drives bank bit (i & m) when (i & m) <= cfg_chip; otherwise it is dropped.
  - ECS hole: when cfg_ecs=1, cfg_chip=0 and cfg_slow!=0, only even i contribute.
- Slow mapping:
  - lim = min(cfg_slow, SLOW_BANKS), reduced by 1 (floor 0) when cfg_aron=1.
  - slow_sel[j] drives bit CHIP_BLOCKS+j for j < lim. Slow blocks beyond lim are dropped.
- Cart: when cfg_aron=1, cart drives bit CHIP_BLOCKS+SLOW_BANKS-1. When cfg_aron=0, cart is ignored.
- Kick: kick drives bit BANK_W-1; kick1mb drives bit BANK_W-2.
- Latency 1: on each clk, bank <= sel_valid ? map : 0 and bank_valid <= sel_valid.
- Unmapped detection: registered with the same latency. unmapped=1 when sel_valid=1, map=0, and at least one select input is high. The counter increments on each unmapped pulse and saturates at all-ones without wrapping.
- A mapping change from a config apply affects the first sel_valid cycle after the apply edge.

Decomposition:
- Package minimig_mem_pkg holds BANK_W, size-code widths, the reset config constant and a function next_pow2_mask(code).
- One sub-module, minimig_bankmap_comb, holds the pure mapping logic. The top level holds the staging register, output register and counter.

Test Plan:
- Reset, then cfg_chip=1, cfg_slow=0, bus_idle=1; chip_sel=4'b0100 with sel_valid -> next cycle bank=8'h01 and bank_valid=1. chip_sel=4'b1000 -> bank=8'h02.
- cfg_chip=2: chip_sel=4'b1000 -> bank=0, unmapped=1, unmapped_cnt=1. chip_sel=4'b0100 -> bank=8'h04.
- cfg_chip=0, cfg_slow=1, cfg_ecs=1: chip_sel=4'b0010 -> unmapped=1. slow_sel=3'b001 -> bank=8'h10. slow_sel=3'b010 -> unmapped.
- cfg_aron=1, cfg_slow=2: cart=1 -> bank=8'h20. slow_sel=3'b010 -> unmapped. kick=1 -> bank=8'h80.
- cfg_wr with bus_idle=0 held 5 cycles -> cfg_pending stays 1 and the old mapping persists. bus_idle=1 -> cfg_pending=0 next cycle and the new mapping is used. Pulse reset_n=0 while pending -> config returns to the reset constant.
- 300 consecutive unmapped accesses -> unmapped_cnt saturates at 8'hFF.
